alu_issue_ctrl: RTL and testbench

//  Initiator side of the ALU interface: accepts one decoded operation over a valid/ready

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_ctrl_decode.sv | 34 +++
 rtl/alu_issue_ctrl.sv | 101 ++++++++++
 tb/tb_alu_issue_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU issue path: ALUOp codes, ALU control
// values and the issue FSM state constants.
package alu_pkg;

    localparam logic [1:0] ALUOP_LDST    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH  = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
    localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

    localparam logic [3:0] ALUCTL_AND = 4'b0000;
    localparam logic [3:0] ALUCTL_OR  = 4'b0001;
    localparam logic [3:0] ALUCTL_ADD = 4'b0010;
    localparam logic [3:0] ALUCTL_SUB = 4'b0110;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct3/funct7[30] decode into the ALU control code plus an
// illegal flag for combinations the ALU does not support.
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter int CTRL_W = 4
) (
    input  logic [1:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic              funct7_30,
    output logic [CTRL_W-1:0] alu_ctl,
    output logic              illegal
);

    always_comb begin
        alu_ctl = '0;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_LDST:   alu_ctl = CTRL_W'(ALUCTL_ADD);
            ALUOP_BRANCH: alu_ctl = CTRL_W'(ALUCTL_SUB);
            ALUOP_RTYPE: begin
                case (funct3)
                    3'b000:  alu_ctl = funct7_30 ? CTRL_W'(ALUCTL_SUB) : CTRL_W'(ALUCTL_ADD);
                    3'b111:  alu_ctl = CTRL_W'(ALUCTL_AND);
                    3'b110:  alu_ctl = CTRL_W'(ALUCTL_OR);
                    default: illegal = 1'b1;
                endcase
            end
            ALUOP_ILLEGAL: illegal = 1'b1;
            default:       illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage initiator for a one-clock registered ALU: accepts a decoded op, drives
// operands/control, captures Result/Zero and returns them over a response handshake.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_alu_op,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7_30,
    input  logic              in_is_branch,
    input  logic [XLEN-1:0]   in_op_a,
    input  logic [XLEN-1:0]   in_op_b,
    output logic [XLEN-1:0]   ReadData1,
    output logic [XLEN-1:0]   ReadData2,
    output logic [CTRL_W-1:0] AluCout,
    input  logic [XLEN-1:0]   AluResult,
    input  logic              AluZero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic              out_zero,
    output logic              out_branch_taken,
    output logic              out_illegal
);

    state_t              state;
    logic                is_branch_q;
    logic [CTRL_W-1:0]   dec_ctl;
    logic                dec_illegal;

    alu_ctrl_decode #(.CTRL_W(CTRL_W)) u_decode (
        .alu_op    (in_alu_op),
        .funct3    (in_funct3),
        .funct7_30 (in_funct7_30),
        .alu_ctl   (dec_ctl),
        .illegal   (dec_illegal)
    );

    // No DONE->accept bypass: a new request is only taken once the response has drained.
    assign in_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            is_branch_q      <= 1'b0;
            ReadData1        <= '0;
            ReadData2        <= '0;
            AluCout          <= '0;
            out_valid        <= 1'b0;
            out_result       <= '0;
            out_zero         <= 1'b0;
            out_branch_taken <= 1'b0;
            out_illegal      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (dec_illegal) begin
                            out_result       <= '0;
                            out_zero         <= 1'b0;
                            out_branch_taken <= 1'b0;
                            out_illegal      <= 1'b1;
                            out_valid        <= 1'b1;
                            state            <= ST_DONE;
                        end else begin
                            ReadData1   <= in_op_a;
                            ReadData2   <= in_op_b;
                            AluCout     <= dec_ctl;
                            is_branch_q <= in_is_branch;
                            state       <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                // ALU output reflects the operands sampled at the end of ISSUE.
                ST_WAIT: begin
                    out_result       <= AluResult;
                    out_zero         <= AluZero;
                    out_branch_taken <= is_branch_q & AluZero;
                    out_illegal      <= 1'b0;
                    out_valid        <= 1'b1;
                    state            <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural one-clock registered ALU.
module tb_alu_issue_ctrl;

    localparam int XLEN   = 64;
    localparam int CTRL_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_alu_op;
    logic [2:0]        in_funct3;
    logic              in_funct7_30;
    logic              in_is_branch;
    logic [XLEN-1:0]   in_op_a;
    logic [XLEN-1:0]   in_op_b;
    logic [XLEN-1:0]   ReadData1;
    logic [XLEN-1:0]   ReadData2;
    logic [CTRL_W-1:0] AluCout;
    logic [XLEN-1:0]   AluResult;
    logic              AluZero;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_result;
    logic              out_zero;
    logic              out_branch_taken;
    logic              out_illegal;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_alu_op        (in_alu_op),
        .in_funct3        (in_funct3),
        .in_funct7_30     (in_funct7_30),
        .in_is_branch     (in_is_branch),
        .in_op_a          (in_op_a),
        .in_op_b          (in_op_b),
        .ReadData1        (ReadData1),
        .ReadData2        (ReadData2),
        .AluCout          (AluCout),
        .AluResult        (AluResult),
        .AluZero          (AluZero),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_zero         (out_zero),
        .out_branch_taken (out_branch_taken),
        .out_illegal      (out_illegal)
    );

    // Registered ALU: and / or / add / sub, zero flag from the computed result.
    logic [XLEN-1:0] alu_next;
    always_comb begin
        alu_next = '0;
        case (AluCout)
            4'b0000: alu_next = ReadData1 & ReadData2;
            4'b0001: alu_next = ReadData1 | ReadData2;
            4'b0010: alu_next = ReadData1 + ReadData2;
            4'b0110: alu_next = ReadData1 - ReadData2;
            default: alu_next = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        AluResult <= alu_next;
        AluZero   <= (alu_next == '0);
    end

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [2:0] f3, input logic b30,
                             input logic br, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        in_valid     = 1'b1;
        in_alu_op    = op;
        in_funct3    = f3;
        in_funct7_30 = b30;
        in_is_branch = br;
        in_op_a      = a;
        in_op_b      = b;
    endtask

    // Accept edge, then ISSUE, WAIT, DONE; response drained with out_ready.
    task automatic run_legal(input string tag, input logic [1:0] op, input logic [2:0] f3,
                             input logic b30, input logic br,
                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             input logic [3:0] exp_ctl, input logic [XLEN-1:0] exp_res,
                             input logic exp_zero, input logic exp_taken);
        drive_req(op, f3, b30, br, a, b);
        step();
        in_valid = 1'b0;
        chk({tag, "_ctl"},       {60'd0, AluCout}, {60'd0, exp_ctl});
        chk({tag, "_rd1"},       ReadData1, a);
        chk({tag, "_rd2"},       ReadData2, b);
        chk({tag, "_busy"},      {63'd0, in_ready}, 64'd0);
        step();
        chk({tag, "_early_vld"}, {63'd0, out_valid}, 64'd0);
        step();
        chk({tag, "_vld"},       {63'd0, out_valid}, 64'd1);
        chk({tag, "_res"},       out_result, exp_res);
        chk({tag, "_zero"},      {63'd0, out_zero}, {63'd0, exp_zero});
        chk({tag, "_taken"},     {63'd0, out_branch_taken}, {63'd0, exp_taken});
        chk({tag, "_ill"},       {63'd0, out_illegal}, 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_drain"},     {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    task automatic run_illegal(input string tag, input logic [1:0] op, input logic [2:0] f3,
                               input logic [XLEN-1:0] prev_a, input logic [3:0] prev_ctl);
        drive_req(op, f3, 1'b0, 1'b1, 64'h1234, 64'h1234);
        step();
        in_valid = 1'b0;
        chk({tag, "_vld"},   {63'd0, out_valid}, 64'd1);
        chk({tag, "_ill"},   {63'd0, out_illegal}, 64'd1);
        chk({tag, "_res"},   out_result, 64'd0);
        chk({tag, "_zt"},    {62'd0, out_zero, out_branch_taken}, 64'd0);
        chk({tag, "_rd1"},   ReadData1, prev_a);
        chk({tag, "_ctl"},   {60'd0, AluCout}, {60'd0, prev_ctl});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_drain"}, {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rdy"},  {63'd0, in_ready}, 64'd1);
        chk({tag, "_vld"},  {63'd0, out_valid}, 64'd0);
        chk({tag, "_rd"},   ReadData1 | ReadData2, 64'd0);
        chk({tag, "_ctl"},  {60'd0, AluCout}, 64'd0);
        chk({tag, "_res"},  out_result, 64'd0);
        chk({tag, "_flg"},  {61'd0, out_zero, out_branch_taken, out_illegal}, 64'd0);
    endtask

    logic [XLEN-1:0] held_res;

    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
        drive_req(2'b00, 3'b000, 1'b0, 1'b0, '0, '0);
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_reset_state("rst");

        run_legal("radd",  2'b10, 3'b000, 1'b0, 1'b0, 64'd5, 64'd7, 4'b0010, 64'd12, 1'b0, 1'b0);
        run_legal("rsub",  2'b10, 3'b000, 1'b1, 1'b0, 64'd9, 64'd9, 4'b0110, 64'd0, 1'b1, 1'b0);
        run_legal("ldst",  2'b00, 3'b101, 1'b1, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFFC,
                  4'b0010, 64'd96, 1'b0, 1'b0);
        run_legal("and",   2'b10, 3'b111, 1'b0, 1'b0, 64'hF0, 64'h3C, 4'b0000, 64'h30, 1'b0, 1'b0);
        run_legal("or",    2'b10, 3'b110, 1'b0, 1'b0, 64'hF0, 64'h3C, 4'b0001, 64'hFC, 1'b0, 1'b0);
        run_illegal("ill11", 2'b11, 3'b000, 64'hF0, 4'b0001);
        run_legal("beq",   2'b01, 3'b000, 1'b0, 1'b1, 64'hDEAD, 64'hDEAD, 4'b0110, 64'd0, 1'b1, 1'b1);
        run_illegal("ill10", 2'b10, 3'b001, 64'hDEAD, 4'b0110);
        run_legal("bne",   2'b01, 3'b000, 1'b0, 1'b1, 64'd1, 64'd2, 4'b0110,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

        // Backpressure: response held four cycles while a new request waits.
        drive_req(2'b10, 3'b000, 1'b0, 1'b0, 64'd20, 64'd22);
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("bp_vld0", {63'd0, out_valid}, 64'd1);
        held_res = 64'd42;
        drive_req(2'b00, 3'b000, 1'b0, 1'b0, 64'd3, 64'd4);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_vld",  {63'd0, out_valid}, 64'd1);
            chk("bp_rdy",  {63'd0, in_ready}, 64'd0);
            chk("bp_res",  out_result, held_res);
            chk("bp_rd1",  ReadData1, 64'd20);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_idle", {62'd0, out_valid, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp_acc_rdy", {63'd0, in_ready}, 64'd0);
        chk("bp_acc_rd1", ReadData1, 64'd3);
        step();
        step();
        chk("bp_next_res", out_result, 64'd7);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset held two clocks while the op sits in WAIT.
        drive_req(2'b10, 3'b000, 1'b0, 1'b0, 64'd11, 64'd13);
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk_reset_state("rstw");
        step();
        step();
        chk("rstw_novld", {63'd0, out_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
